// File: rtl/gmem_pkg.sv
// Shared types and constants for the gmem AXI <-> TSIM bridges.
package gmem_pkg;

    localparam int unsigned GMEM_LEN_BITS    = 8;
    localparam int unsigned GMEM_ADDR_BITS   = 32;
    localparam int unsigned GMEM_DATA_BITS   = 64;
    localparam int unsigned GMEM_AXI_ID_BITS = 1;
    localparam int unsigned GMEM_FIFO_DEPTH  = 4;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData
    } rd_state_e;

endpackage

// File: rtl/gmem_rd_fifo.sv
// Synchronous FIFO with a registered storage head; shared by the gmem read and write bridges.
module gmem_rd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/gmem_rd_bridge.sv
// AXI4 read (AR/R) to TSIM read bridge: one TSIM request per burst, beats replayed via a FIFO.
module gmem_rd_bridge
    import gmem_pkg::*;
#(
    parameter int unsigned MEM_LEN_BITS    = GMEM_LEN_BITS,
    parameter int unsigned MEM_ADDR_BITS   = GMEM_ADDR_BITS,
    parameter int unsigned MEM_DATA_BITS   = GMEM_DATA_BITS,
    parameter int unsigned MEM_AXI_ID_BITS = GMEM_AXI_ID_BITS,
    parameter int unsigned FIFO_DEPTH      = GMEM_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       m_axi_gmem_ARVALID,
    output logic                       m_axi_gmem_ARREADY,
    input  logic [MEM_ADDR_BITS-1:0]   m_axi_gmem_ARADDR,
    input  logic [MEM_AXI_ID_BITS-1:0] m_axi_gmem_ARID,
    input  logic [MEM_LEN_BITS-1:0]    m_axi_gmem_ARLEN,
    output logic                       m_axi_gmem_RVALID,
    input  logic                       m_axi_gmem_RREADY,
    output logic [MEM_DATA_BITS-1:0]   m_axi_gmem_RDATA,
    output logic [MEM_AXI_ID_BITS-1:0] m_axi_gmem_RID,
    output logic                       m_axi_gmem_RLAST,
    output logic [1:0]                 m_axi_gmem_RRESP,
    output logic                       mem_req_valid,
    output logic                       mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]    mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    input  logic                       mem_rd_valid,
    output logic                       mem_rd_ready,
    input  logic [MEM_DATA_BITS-1:0]   mem_rd_bits
);

    // One extra bit so a 256-beat burst can count past len without wrapping.
    localparam int unsigned CntBits = MEM_LEN_BITS + 1;

    rd_state_e                  state_q, state_d;
    logic [MEM_ADDR_BITS-1:0]   addr_q;
    logic [MEM_AXI_ID_BITS-1:0] id_q;
    logic [MEM_LEN_BITS-1:0]    len_q;
    logic [CntBits-1:0]         rx_cnt_q, tx_cnt_q;
    logic                       ar_hs, rd_hs, r_hs, is_last;
    logic                       fifo_full, fifo_empty;

    assign ar_hs   = m_axi_gmem_ARVALID && m_axi_gmem_ARREADY;
    assign rd_hs   = mem_rd_valid && mem_rd_ready;
    assign r_hs    = m_axi_gmem_RVALID && m_axi_gmem_RREADY;
    assign is_last = (tx_cnt_q == {1'b0, len_q});

    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ar_hs) state_d = StReq;
            StReq:   state_d = StData;
            StData:  if (r_hs && is_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_axi_gmem_ARREADY = (state_q == StIdle) && !reset;
        mem_req_valid      = (state_q == StReq);
        mem_rd_ready       = (state_q == StData) && !fifo_full && (rx_cnt_q <= {1'b0, len_q});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else if (ar_hs) begin
            addr_q   <= m_axi_gmem_ARADDR;
            id_q     <= m_axi_gmem_ARID;
            len_q    <= m_axi_gmem_ARLEN;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rd_hs) rx_cnt_q <= rx_cnt_q + 1'b1;
            if (r_hs)  tx_cnt_q <= tx_cnt_q + 1'b1;
        end
    end

    gmem_rd_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(MEM_DATA_BITS)
    ) u_fifo (
        .clk_i  (clock),
        .rst_i  (reset),
        .push_i (rd_hs),
        .data_i (mem_rd_bits),
        .pop_i  (r_hs),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (m_axi_gmem_RDATA)
    );

    assign m_axi_gmem_RVALID = !fifo_empty;
    assign m_axi_gmem_RLAST  = m_axi_gmem_RVALID && is_last;
    assign m_axi_gmem_RID    = id_q;
    assign m_axi_gmem_RRESP  = AXI_RESP_OKAY;
    assign mem_req_opcode    = MEM_OP_RD;
    assign mem_req_len       = len_q;
    assign mem_req_addr      = addr_q;

endmodule

// File: tb/tb_gmem_rd_bridge.sv
// Randomized bench for gmem_rd_bridge: per-cycle compare against a queue-based burst model.
module tb_gmem_rd_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] ARADDR = '0;
    logic [0:0]  ARID = '0;
    logic [7:0]  ARLEN = '0;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [63:0] RDATA;
    logic [0:0]  RID;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        req_valid, req_opcode;
    logic [7:0]  req_len;
    logic [31:0] req_addr;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [63:0] rd_bits = '0;

    gmem_rd_bridge dut (
        .clock             (clk),
        .reset             (reset),
        .m_axi_gmem_ARVALID(ARVALID),
        .m_axi_gmem_ARREADY(ARREADY),
        .m_axi_gmem_ARADDR (ARADDR),
        .m_axi_gmem_ARID   (ARID),
        .m_axi_gmem_ARLEN  (ARLEN),
        .m_axi_gmem_RVALID (RVALID),
        .m_axi_gmem_RREADY (RREADY),
        .m_axi_gmem_RDATA  (RDATA),
        .m_axi_gmem_RID    (RID),
        .m_axi_gmem_RLAST  (RLAST),
        .m_axi_gmem_RRESP  (RRESP),
        .mem_req_valid     (req_valid),
        .mem_req_opcode    (req_opcode),
        .mem_req_len       (req_len),
        .mem_req_addr      (req_addr),
        .mem_rd_valid      (rd_valid),
        .mem_rd_ready      (rd_ready),
        .mem_rd_bits       (rd_bits)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs (main) and logs (monitor).
    int          rd_prob = 100;
    int          rr_prob = 100;
    bit          rand_data = 1'b0;
    logic [63:0] data_base = '0;
    int          cyc = 0;
    int          rd_hs_cnt = 0;
    int          bursts_done = 0;
    int          req_cnt = 0;
    logic [31:0] req_addr_log = '0;
    logic [7:0]  req_len_log = '0;
    logic [63:0] r_log[$];
    bit          rlast_log[$];
    bit          rid_log[$];
    int          r_cyc[$];
    int          ar_cyc[$];

    // Behavioural model: where the burst is, what it latched, and the beats held in the buffer.
    int          m_phase = 0;
    logic [31:0] m_addr = '0;
    logic [0:0]  m_id = '0;
    int          m_len = 0;
    int          m_rx = 0;
    int          m_tx = 0;
    logic [63:0] m_q[$];

    always @(negedge clk) begin
        logic e_arready, e_rvalid, e_rlast, e_rd_ready, p, g;
        cyc++;
        e_arready  = (m_phase == 0) && !reset;
        e_rvalid   = (m_q.size() > 0);
        e_rlast    = e_rvalid && (m_tx == m_len);
        e_rd_ready = (m_phase == 2) && (m_q.size() < 4) && (m_rx <= m_len);
        chk("arready", ARREADY, e_arready);
        chk("req_valid", req_valid, m_phase == 1);
        chk("req_opcode", req_opcode, 0);
        chk("req_addr", req_addr, m_addr);
        chk("req_len", req_len, m_len);
        chk("rd_ready", rd_ready, e_rd_ready);
        chk("rvalid", RVALID, e_rvalid);
        chk("rlast", RLAST, e_rlast);
        chk("rid", RID, m_id);
        chk("rresp", RRESP, 0);
        if (e_rvalid) chk("rdata", RDATA, m_q[0]);

        if (!reset) begin
            if (ARVALID && ARREADY) ar_cyc.push_back(cyc);
            if (req_valid) begin
                req_cnt++;
                req_addr_log = req_addr;
                req_len_log  = req_len;
            end
            if (rd_valid && rd_ready) rd_hs_cnt++;
            if (RVALID && RREADY) begin
                r_log.push_back(RDATA);
                rlast_log.push_back(RLAST);
                rid_log.push_back(RID[0]);
                r_cyc.push_back(cyc);
                if (RLAST) bursts_done++;
            end
        end

        if (reset) begin
            m_phase = 0; m_addr = '0; m_id = '0; m_len = 0; m_rx = 0; m_tx = 0;
            m_q.delete();
        end else begin
            p = e_rvalid && RREADY;
            g = e_rd_ready && rd_valid;
            case (m_phase)
                0: if (ARVALID) begin
                    m_addr = ARADDR; m_id = ARID; m_len = int'(ARLEN);
                    m_rx = 0; m_tx = 0; m_phase = 1;
                end
                1: m_phase = 2;
                default: begin
                    if (p) begin
                        m_q.delete(0);
                        m_tx++;
                        if (e_rlast) m_phase = 0;
                    end
                    if (g) begin
                        m_q.push_back(rd_bits);
                        m_rx++;
                    end
                end
            endcase
        end
    end

    // Memory-side and R-side driver; indexed data is base + number of beats already consumed.
    initial forever begin
        @(posedge clk);
        #1;
        rd_valid = ($urandom_range(99) < rd_prob);
        rd_bits  = rand_data ? {$urandom, $urandom} : data_base + 64'(rd_hs_cnt);
        RREADY   = ($urandom_range(99) < rr_prob);
    end

    task automatic clear_logs();
        r_log.delete(); rlast_log.delete(); rid_log.delete(); r_cyc.delete(); ar_cyc.delete();
        rd_hs_cnt = 0; req_cnt = 0;
    endtask

    // Presents an AR and returns at the negedge before the handshake edge, ARVALID still high.
    task automatic start_ar(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        ARVALID = 1'b1; ARADDR = a; ARID = id; ARLEN = len;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ARREADY) begin
                got = 1'b1;
                break;
            end
        end
        chk("ar_handshake_seen", got, 1);
    endtask

    task automatic drop_ar();
        @(posedge clk);
        #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bursts_done >= target) break;
        end
        chk("burst_completed", bursts_done >= target, 1);
    endtask

    task automatic chk_data(input string nm, input int n, input logic [63:0] base);
        chk({nm, "_beats"}, r_log.size(), n);
        for (int i = 0; i < r_log.size() && i < n; i++) begin
            chk({nm, "_data"}, r_log[i], base + 64'(i));
            chk({nm, "_rlast"}, rlast_log[i], i == n - 1);
        end
    endtask

    initial begin
        int tgt, len;
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, len;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_rd_ready", rd_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", ARREADY, 1);

        // Single beat.
        clear_logs();
        data_base = 64'hDEAD_BEEF_0000_0000;
        tgt = bursts_done + 1;
        start_ar(32'h1000, 1'b1, 8'd0);
        drop_ar();
        wait_done(tgt, 200);
        chk_data("single", 1, 64'hDEAD_BEEF_0000_0000);
        chk("single_req_cnt", req_cnt, 1);
        chk("single_req_addr", req_addr_log, 32'h1000);
        chk("single_req_len", req_len_log, 0);
        if (r_log.size() == 1 && ar_cyc.size() == 1) begin
            chk("single_rid", rid_log[0], 1);
            chk("single_latency", r_cyc[0] - ar_cyc[0], 3);
        end

        // 16 beats at full rate.
        clear_logs();
        data_base = '0;
        tgt = bursts_done + 1;
        start_ar(32'h2000, 1'b0, 8'd15);
        drop_ar();
        wait_done(tgt, 200);
        chk_data("burst16", 16, 64'd0);
        if (r_cyc.size() == 16) chk("burst16_rate", r_cyc[15] - r_cyc[0], 15);

        // Backpressure: RREADY low for 10 cycles fills the 4-entry buffer.
        clear_logs();
        data_base = 64'h100;
        rr_prob = 0;
        tgt = bursts_done + 1;
        start_ar(32'h3000, 1'b1, 8'd7);
        drop_ar();
        repeat (10) @(negedge clk);
        chk("bp_beats_buffered", rd_hs_cnt, 4);
        rr_prob = 100;
        wait_done(tgt, 200);
        chk_data("bp", 8, 64'h100);

        // 256 beats with random handshakes.
        clear_logs();
        data_base = 64'h5000;
        rd_prob = 70; rr_prob = 70;
        tgt = bursts_done + 1;
        start_ar(32'h4000, 1'b0, 8'd255);
        drop_ar();
        wait_done(tgt, 5000);
        chk_data("b256", 256, 64'h5000);

        // Back-to-back with ARVALID held; memory keeps offering beats in between.
        clear_logs();
        data_base = 64'h900;
        rd_prob = 100; rr_prob = 100;
        tgt = bursts_done + 2;
        start_ar(32'h6000, 1'b0, 8'd3);
        start_ar(32'h7000, 1'b1, 8'd2);
        drop_ar();
        wait_done(tgt, 300);
        chk("b2b_beats", r_log.size(), 7);
        if (r_log.size() == 7 && ar_cyc.size() == 2) begin
            chk("b2b_ar_gap", ar_cyc[1] - r_cyc[3], 1);
            for (int i = 0; i < 7; i++) begin
                chk("b2b_data", r_log[i], 64'h900 + 64'(i));
                chk("b2b_rid", rid_log[i], i >= 4);
                chk("b2b_rlast", rlast_log[i], (i == 3) || (i == 6));
            end
        end

        // Reset after 3 of 8 beats have been accepted.
        clear_logs();
        rr_prob = 0;
        start_ar(32'h8000, 1'b1, 8'd7);
        drop_ar();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_hs_cnt >= 3) break;
        end
        chk("mid_rd_beats", rd_hs_cnt, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_arready", ARREADY, 0);
        chk("mid_rst_rvalid", RVALID, 0);
        chk("mid_rst_rdata", RDATA, 0);
        chk("mid_rst_rid", RID, 0);
        chk("mid_rst_req_len", req_len, 0);
        chk("mid_rst_rd_ready", rd_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_post_arready", ARREADY, 1);
        clear_logs();
        data_base = 64'hA00;
        rr_prob = 100;
        tgt = bursts_done + 1;
        start_ar(32'h9000, 1'b0, 8'd3);
        drop_ar();
        wait_done(tgt, 200);
        chk_data("fresh", 4, 64'hA00);

        // Random bursts with random data and handshake rates.
        rand_data = 1'b1;
        for (int b = 0; b < 12; b++) begin
            clear_logs();
            rd_prob = $urandom_range(30, 100);
            rr_prob = $urandom_range(30, 100);
            len = $urandom_range(0, 20);
            tgt = bursts_done + 1;
            start_ar($urandom, 1'($urandom), 8'(len));
            drop_ar();
            wait_done(tgt, 1000);
            chk("rand_beats", r_log.size(), len + 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
